// File: rtl/bus_strobe_drv_pkg.sv
// Shared definitions for the strobed bus driver: channel state encoding,
// a constant-safe clog2/max helper pair and the legacy G/H path defaults.
// Imported by the channel FSM and the top-level wrapper.
package bus_strobe_drv_pkg;

   // Channel states; INIT is only ever entered from reset
   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_SETUP = 3'd2,
      ST_PULSE = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   // Legacy G/H path defaults: GDELAY-derived pulse, CFG word on strobe 3'b100
   localparam int         DEF_PULSE   = 3;
   localparam logic [7:0] DEF_CFG     = 8'h09;
   localparam logic [2:0] DEF_CFG_STB = 3'b100;

   // Ceiling log2, never below 1 so a counter always has at least one bit
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bus_strobe_chan.sv
// One bus channel: latches a word on accept, drives it, then fires one strobe.
// Latency: bus valid one cycle after accept; strobe after SETUP, PULSE long, HOLD.
// Backpressure: rdy only in IDLE; requests while busy are dropped, not queued.
module bus_strobe_chan
   import bus_strobe_drv_pkg::*;
#(
   parameter int             DW        = 8,
   parameter int             NSTB      = 3,
   parameter int             SW        = 2,
   parameter int             SETUP     = 1,
   parameter int             PULSE     = 3,
   parameter int             HOLD      = 1,
   parameter bit             INIT_EN   = 1'b0,
   parameter logic [DW-1:0]  INIT_DATA = '0,
   parameter logic [SW-1:0]  INIT_SEL  = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req,
   input  logic [SW-1:0]   sel,
   input  logic [DW-1:0]   din,
   output logic            rdy,
   output logic [DW-1:0]   bus,
   output logic [NSTB-1:0] stb,
   output logic            sel_err
);

   localparam int CW = clog2(max3(SETUP, PULSE, HOLD) + 1);

   // Counter reload values: a state lasting N cycles counts N-1 .. 0
   localparam logic [CW-1:0] LD_SETUP = CW'((SETUP > 0) ? SETUP - 1 : 0);
   localparam logic [CW-1:0] LD_PULSE = CW'((PULSE > 0) ? PULSE - 1 : 0);
   localparam logic [CW-1:0] LD_HOLD  = CW'((HOLD  > 0) ? HOLD  - 1 : 0);

   localparam state_t RST_STATE = INIT_EN ? ST_INIT : ST_IDLE;
   localparam logic [DW-1:0] RST_BUS = INIT_EN ? INIT_DATA : '0;

   state_t            state, nxt_state;
   logic [CW-1:0]     cnt, nxt_cnt;
   logic [SW-1:0]     sel_q, nxt_sel;
   logic [NSTB-1:0]   stb_d;
   logic              accept;

   // Idle channels advertise readiness; held low while reset is asserted
   assign rdy = rst_n && (state == ST_IDLE);

   // Next state, counter reload and registered-strobe decode
   always_comb begin
      nxt_state = state;
      nxt_cnt   = (cnt != '0) ? cnt - 1'b1 : '0;
      accept    = 1'b0;
      stb_d     = '0;
      unique case (state)
         // The init word was loaded by reset, so INIT plays the role of SETUP
         ST_INIT: begin
            if (cnt == '0) begin
               nxt_state = ST_PULSE;
               nxt_cnt   = LD_PULSE;
            end
         end
         ST_IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (SETUP > 0) begin
                  nxt_state = ST_SETUP;
                  nxt_cnt   = LD_SETUP;
               end else begin
                  nxt_state = ST_PULSE;
                  nxt_cnt   = LD_PULSE;
               end
            end
         end
         ST_SETUP: begin
            if (cnt == '0) begin
               nxt_state = ST_PULSE;
               nxt_cnt   = LD_PULSE;
            end
         end
         ST_PULSE: begin
            if (cnt == '0) begin
               if (HOLD > 0) begin
                  nxt_state = ST_HOLD;
                  nxt_cnt   = LD_HOLD;
               end else begin
                  nxt_state = ST_IDLE;
               end
            end
         end
         ST_HOLD: begin
            if (cnt == '0) nxt_state = ST_IDLE;
         end
         default: nxt_state = ST_IDLE;
      endcase
      nxt_sel = accept ? sel : sel_q;
      // Out-of-range selects match no line, so the strobe stays dark
      if (nxt_state == ST_PULSE) begin
         for (int j = 0; j < NSTB; j++) begin
            stb_d[j] = (nxt_sel == SW'(j));
         end
      end
   end

   // State, counter, latched word/select and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RST_STATE;
         cnt     <= LD_SETUP;
         sel_q   <= INIT_SEL;
         bus     <= RST_BUS;
         stb     <= '0;
         sel_err <= 1'b0;
      end else begin
         state   <= nxt_state;
         cnt     <= nxt_cnt;
         sel_q   <= nxt_sel;
         stb     <= stb_d;
         sel_err <= accept && (int'(sel) >= NSTB);
         if (accept) bus <= din;
      end
   end

endmodule

// File: rtl/bus_strobe_drv.sv
// N independent strobed bus channels behind flat request/data/strobe vectors.
// Latency: per channel, bus one cycle after accept; strobe SETUP cycles later.
// Backpressure: per-channel rdy; a request is taken only when its rdy is high.
module bus_strobe_drv
   import bus_strobe_drv_pkg::*;
#(
   parameter int                  NCH       = 2,
   parameter int                  DW        = 8,
   parameter int                  NSTB      = 3,
   parameter int                  SW        = 2,
   parameter int                  SETUP     = 1,
   parameter int                  PULSE     = DEF_PULSE,
   parameter int                  HOLD      = 1,
   parameter logic [NCH-1:0]      INIT_EN   = 2'b10,
   parameter logic [NCH*DW-1:0]   INIT_DATA = 16'h0900,
   parameter logic [NCH*SW-1:0]   INIT_SEL  = 4'b1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       req,
   input  logic [NCH*SW-1:0]    sel,
   input  logic [NCH*DW-1:0]    din,
   output logic [NCH-1:0]       rdy,
   output logic [NCH*DW-1:0]    bus,
   output logic [NCH*NSTB-1:0]  stb,
   output logic [NCH-1:0]       sel_err
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      bus_strobe_chan #(
         .DW        (DW),
         .NSTB      (NSTB),
         .SW        (SW),
         .SETUP     (SETUP),
         .PULSE     (PULSE),
         .HOLD      (HOLD),
         .INIT_EN   (INIT_EN[i]),
         .INIT_DATA (INIT_DATA[i*DW +: DW]),
         .INIT_SEL  (INIT_SEL[i*SW +: SW])
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .req     (req[i]),
         .sel     (sel[i*SW +: SW]),
         .din     (din[i*DW +: DW]),
         .rdy     (rdy[i]),
         .bus     (bus[i*DW +: DW]),
         .stb     (stb[i*NSTB +: NSTB]),
         .sel_err (sel_err[i])
      );
   end

endmodule
